// File: rtl/ppl_mem_stage.sv
// MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
// Performs the data-memory access on a synchronous word RAM with MEM_WAIT wait
// states, stalls upstream while an access is in flight, and registers the result
// into the MEM/WB boundary.
//
// Ports:
//   clk, reset            clock (posedge) and synchronous active-high reset
//   mWriteReg, mMem2Reg   EX/MEM control: register write enable, load select
//   mWriteMem             EX/MEM control: store
//   mAlu                  ALU result, also the byte address of the access
//   mReg, mDataB          destination register and store data
//   memStall              hold upstream stages and the EX/MEM inputs stable
//   wb*                   MEM/WB register outputs (bubble = all zero)
module ppl_mem_stage #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mWriteReg,
  input  logic        mMem2Reg,
  input  logic        mWriteMem,
  input  logic [31:0] mAlu,
  input  logic [4:0]  mReg,
  input  logic [31:0] mDataB,
  output logic        memStall,
  output logic        wbWriteReg,
  output logic        wbMem2Reg,
  output logic [31:0] wbAlu,
  output logic [31:0] wbMemOut,
  output logic [4:0]  wbReg
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(MEM_WAIT - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  access;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           ram [2**ADDR_WIDTH];

  assign access = mMem2Reg | mWriteMem;
  // Byte offset and bits above the RAM depth are dropped, so addresses alias.
  assign addr   = mAlu[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mAlu[31:ADDR_WIDTH+2], mAlu[1:0]};

  // complete marks the cycle whose edge commits the instruction into MEM/WB.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!access || MEM_WAIT == 0) begin
          complete = 1'b1;
        end else if (MEM_WAIT == 1) begin
          state_d = StDone;
        end else begin
          state_d = StBusy;
          cnt_d   = WaitInit;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        complete = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign memStall = ~reset & ~complete;

  // Write only on the completing edge; a store cut short by reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && complete && mWriteMem) begin
      ram[addr] <= mDataB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wbWriteReg <= 1'b0;
      wbMem2Reg  <= 1'b0;
      wbAlu      <= '0;
      wbMemOut   <= '0;
      wbReg      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete) begin
        wbWriteReg <= mWriteReg;
        wbMem2Reg  <= mMem2Reg;
        wbAlu      <= mAlu;
        wbReg      <= mReg;
        // Non-blocking read of the pre-write contents gives read-before-write.
        wbMemOut   <= mMem2Reg ? ram[addr] : '0;
      end else begin
        wbWriteReg <= 1'b0;
        wbMem2Reg  <= 1'b0;
        wbAlu      <= '0;
        wbMemOut   <= '0;
        wbReg      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ppl_mem_stage.sv
module tb_ppl_mem_stage;

  logic clk = 1'b0;
  logic reset;

  // Main instance: MEM_WAIT = 2
  logic        mWriteReg, mMem2Reg, mWriteMem;
  logic [31:0] mAlu, mDataB;
  logic [4:0]  mReg;
  logic        memStall, wbWriteReg, wbMem2Reg;
  logic [31:0] wbAlu, wbMemOut;
  logic [4:0]  wbReg;

  // Zero-wait instance
  logic        z_write_reg, z_mem2reg, z_write_mem;
  logic [31:0] z_alu, z_data_b;
  logic [4:0]  z_reg;
  logic        z_stall, z_wb_write_reg, z_wb_mem2reg;
  logic [31:0] z_wb_alu, z_wb_mem_out;
  logic [4:0]  z_wb_reg;

  int n_assert = 0;
  int n_fail   = 0;

  ppl_mem_stage #(.ADDR_WIDTH(8), .MEM_WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .mWriteReg  (mWriteReg),
    .mMem2Reg   (mMem2Reg),
    .mWriteMem  (mWriteMem),
    .mAlu       (mAlu),
    .mReg       (mReg),
    .mDataB     (mDataB),
    .memStall   (memStall),
    .wbWriteReg (wbWriteReg),
    .wbMem2Reg  (wbMem2Reg),
    .wbAlu      (wbAlu),
    .wbMemOut   (wbMemOut),
    .wbReg      (wbReg)
  );

  ppl_mem_stage #(.ADDR_WIDTH(8), .MEM_WAIT(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .mWriteReg  (z_write_reg),
    .mMem2Reg   (z_mem2reg),
    .mWriteMem  (z_write_mem),
    .mAlu       (z_alu),
    .mReg       (z_reg),
    .mDataB     (z_data_b),
    .memStall   (z_stall),
    .wbWriteReg (z_wb_write_reg),
    .wbMem2Reg  (z_wb_mem2reg),
    .wbAlu      (z_wb_alu),
    .wbMemOut   (z_wb_mem_out),
    .wbReg      (z_wb_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".wbWriteReg"}, {31'd0, wbWriteReg}, 32'd0);
    chk({tag, ".wbMem2Reg"},  {31'd0, wbMem2Reg},  32'd0);
    chk({tag, ".wbAlu"},      wbAlu,               32'd0);
    chk({tag, ".wbMemOut"},   wbMemOut,            32'd0);
    chk({tag, ".wbReg"},      {27'd0, wbReg},      32'd0);
  endtask

  task automatic set_in(input logic we, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [4:0] rg, input logic [31:0] db);
    mWriteReg = we;
    mMem2Reg  = rd;
    mWriteMem = wr;
    mAlu      = alu;
    mReg      = rg;
    mDataB    = db;
  endtask

  // One full access on the MEM_WAIT=2 instance: two stall cycles with bubbles,
  // then the result cycle.
  task automatic access(input string tag, input logic we, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [4:0] rg, input logic [31:0] db,
                        input logic [31:0] exp_mem);
    set_in(we, rd, wr, alu, rg, db);
    #1;
    chk({tag, ".stall0"}, {31'd0, memStall}, 32'd1);
    tick();
    chk({tag, ".stall1"}, {31'd0, memStall}, 32'd1);
    chk_bubble({tag, ".bub1"});
    tick();
    chk({tag, ".stall2"}, {31'd0, memStall}, 32'd0);
    chk_bubble({tag, ".bub2"});
    tick();
    chk({tag, ".wbWriteReg"}, {31'd0, wbWriteReg}, {31'd0, we});
    chk({tag, ".wbMem2Reg"},  {31'd0, wbMem2Reg},  {31'd0, rd});
    chk({tag, ".wbAlu"},      wbAlu,               alu);
    chk({tag, ".wbReg"},      {27'd0, wbReg},      {27'd0, rg});
    chk({tag, ".wbMemOut"},   wbMemOut,            exp_mem);
  endtask

  initial begin
    logic [31:0] pre [4];
    pre[0] = 32'hA0A0_0001;
    pre[1] = 32'hB1B1_0002;
    pre[2] = 32'hC2C2_0003;
    pre[3] = 32'hD3D3_0004;

    z_write_reg = 1'b0; z_mem2reg = 1'b0; z_write_mem = 1'b0;
    z_alu = '0; z_reg = '0; z_data_b = '0;

    // 1. Reset with random inputs
    reset = 1'b1;
    set_in(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 5'($urandom), $urandom);
    #1;
    chk("rst.stall_pre", {31'd0, memStall}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.stall", {31'd0, memStall}, 32'd0);
      chk_bubble("rst");
      set_in(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 5'($urandom), $urandom);
      #1;
      chk("rst.stall_rand", {31'd0, memStall}, 32'd0);
    end

    // 2. Non-memory instruction: latency 1, no stall
    reset = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 32'h0000_1234, 5'd5, 32'h0);
    #1;
    chk("alu.stall", {31'd0, memStall}, 32'd0);
    tick();
    chk("alu.wbWriteReg", {31'd0, wbWriteReg}, 32'd1);
    chk("alu.wbMem2Reg",  {31'd0, wbMem2Reg},  32'd0);
    chk("alu.wbAlu",      wbAlu,               32'h0000_1234);
    chk("alu.wbReg",      {27'd0, wbReg},      32'd5);
    chk("alu.wbMemOut",   wbMemOut,            32'd0);

    // 3. Store then load
    access("st10", 1'b0, 1'b0, 1'b1, 32'h10, 5'd0, 32'hDEAD_BEEF, 32'h0);
    access("ld10", 1'b1, 1'b1, 1'b0, 32'h10, 5'd7, 32'h0, 32'hDEAD_BEEF);

    // Load+store together returns the old word, then the new one is visible
    access("rw10", 1'b1, 1'b1, 1'b1, 32'h10, 5'd9, 32'h0000_0055, 32'hDEAD_BEEF);
    access("ld10b", 1'b1, 1'b1, 1'b0, 32'h10, 5'd3, 32'h0, 32'h0000_0055);

    // 4. Store aborted by reset during BUSY
    access("st20", 1'b0, 1'b0, 1'b1, 32'h20, 5'd0, 32'h1111_1111, 32'h0);
    set_in(1'b0, 1'b0, 1'b1, 32'h20, 5'd0, 32'h2222_2222);
    #1;
    chk("abort.stall0", {31'd0, memStall}, 32'd1);
    tick();
    chk("abort.stall1", {31'd0, memStall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.stall_rst", {31'd0, memStall}, 32'd0);
    tick();
    chk("abort.stall_rst2", {31'd0, memStall}, 32'd0);
    chk_bubble("abort");
    reset = 1'b0;
    access("ld20", 1'b1, 1'b1, 1'b0, 32'h20, 5'd4, 32'h0, 32'h1111_1111);

    // 5. Address aliasing above the RAM depth
    access("st400", 1'b0, 1'b0, 1'b1, 32'h0000_0400, 5'd0, 32'hCAFE_0001, 32'h0);
    access("ld000", 1'b1, 1'b1, 1'b0, 32'h0000_0003, 5'd6, 32'h0, 32'hCAFE_0001);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);

    // 6. MEM_WAIT=0: preload then four back-to-back loads
    for (int i = 0; i < 4; i++) begin
      z_write_reg = 1'b0; z_mem2reg = 1'b0; z_write_mem = 1'b1;
      z_alu = 32'h40 + 32'(i * 4); z_reg = 5'd0; z_data_b = pre[i];
      #1;
      chk("z.st.stall", {31'd0, z_stall}, 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      z_write_reg = 1'b1; z_mem2reg = 1'b1; z_write_mem = 1'b0;
      z_alu = 32'h40 + 32'(i * 4); z_reg = 5'(10 + i); z_data_b = '0;
      #1;
      chk("z.ld.stall", {31'd0, z_stall}, 32'd0);
      tick();
      chk("z.ld.wbMemOut",   z_wb_mem_out,              pre[i]);
      chk("z.ld.wbReg",      {27'd0, z_wb_reg},         32'(10 + i));
      chk("z.ld.wbWriteReg", {31'd0, z_wb_write_reg},   32'd1);
    end
    z_mem2reg = 1'b0; z_write_reg = 1'b0;
    #1;
    chk("z.idle.stall", {31'd0, z_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
